// File: rtl/rom_fetch_arbiter.sv
// Two-port round-robin read arbiter in front of a byte-addressed big-endian instruction ROM.
// Latency: accept at cycle N -> response valid at N+2 (good read) or N+1 (error).
// Backpressure: one read outstanding; response held until taken, no requests accepted meanwhile.
module rom_fetch_arbiter #(
  parameter int ROM_BYTES = 100,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_req0_valid,
  input  logic [31:0]      i_req0_addr,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [31:0]      i_req1_addr,
  output logic             o_req1_ready,
  output logic             o_resp_valid,
  output logic [31:0]      o_resp_data,
  output logic             o_resp_id,
  output logic             o_resp_err,
  input  logic             i_resp_ready,
  output logic             o_rom_nrd,
  output logic [31:0]      o_rom_addr,
  input  logic [31:0]      i_rom_data,
  output logic [CNT_W-1:0] o_rd_count,
  output logic [CNT_W-1:0] o_err_count
);

  // Highest legal word address; compared unsigned over the full 32 bits so nothing wraps.
  localparam logic [31:0] LP_MAX_ADDR = 32'(ROM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last_grant;
  logic               r_resp_valid;
  logic [31:0]        r_resp_data;
  logic               r_resp_id;
  logic               r_resp_err;
  logic               r_rom_nrd;
  logic [31:0]        r_rom_addr;
  logic [CNT_W-1:0]   r_rd_count;
  logic [CNT_W-1:0]   r_err_count;

  logic               w_grant;
  logic               w_accept;
  logic [31:0]        w_addr;
  logic               w_err;
  logic               w_hs;

  // Round-robin grant and address check; readys only in IDLE and never during reset.
  always_comb begin
    w_grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (i_req1_valid) begin
      w_grant = 1'b1;
    end
    w_accept     = (r_state == S_IDLE) && i_nrst && (i_req0_valid || i_req1_valid);
    o_req0_ready = w_accept && !w_grant;
    o_req1_ready = w_accept && w_grant;
    w_addr       = w_grant ? i_req1_addr : i_req0_addr;
    w_err        = (w_addr[1:0] != 2'b00) || (w_addr > LP_MAX_ADDR);
    w_hs         = r_resp_valid && i_resp_ready;
  end

  // Next-state logic: errors skip the ROM cycle entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_err ? S_RESP : S_READ;
      S_READ:  w_next_state = S_RESP;
      S_RESP:  if (w_hs) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: ROM strobe, response holding register and saturating completion counters.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_last_grant <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_id    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rom_nrd    <= 1'b1;
      r_rom_addr   <= 32'd0;
      r_rd_count   <= '0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant;
            r_resp_id    <= w_grant;
            if (w_err) begin
              r_resp_data  <= 32'd0;
              r_resp_err   <= 1'b1;
              r_resp_valid <= 1'b1;
            end else begin
              r_rom_addr <= w_addr;
              r_rom_nrd  <= 1'b0;
            end
          end
        end
        S_READ: begin
          r_resp_data  <= i_rom_data;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_rom_nrd    <= 1'b1;
          r_rom_addr   <= 32'd0;
        end
        S_RESP: begin
          if (w_hs) begin
            r_resp_valid <= 1'b0;
            if (r_resp_err) begin
              if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
            end else begin
              if (r_rd_count != '1) r_rd_count <= r_rd_count + CNT_W'(1);
            end
          end
        end
        default: begin
          r_rom_nrd <= 1'b1;
        end
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_id    = r_resp_id;
  assign o_resp_err   = r_resp_err;
  assign o_rom_nrd    = r_rom_nrd;
  assign o_rom_addr   = r_rom_addr;
  assign o_rd_count   = r_rd_count;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Model tracks one outstanding transaction by accept cycle and predicts every output each cycle.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        v0, v1, rr;
  logic [31:0] a0, a1;
  logic        o_req0_ready, o_req1_ready;
  logic        o_resp_valid, o_resp_id, o_resp_err;
  logic [31:0] o_resp_data;
  logic        o_rom_nrd;
  logic [31:0] o_rom_addr;
  logic [31:0] rom_data;
  logic [15:0] o_rd_count, o_err_count;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] rom [0:99];

  always #5 clk = ~clk;

  rom_fetch_arbiter #(.ROM_BYTES(100), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_req0_valid (v0),
    .i_req0_addr  (a0),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (v1),
    .i_req1_addr  (a1),
    .o_req1_ready (o_req1_ready),
    .o_resp_valid (o_resp_valid),
    .o_resp_data  (o_resp_data),
    .o_resp_id    (o_resp_id),
    .o_resp_err   (o_resp_err),
    .i_resp_ready (rr),
    .o_rom_nrd    (o_rom_nrd),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (rom_data),
    .o_rd_count   (o_rd_count),
    .o_err_count  (o_err_count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    i = int'(a);
    return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
  endfunction

  // ROM drives a poison pattern when not read, so a capture outside READ is visible.
  always_comb begin
    rom_data = 32'hDEAD_BEEF;
    if (!o_rom_nrd && o_rom_addr <= 32'd96) rom_data = word_at(o_rom_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: one pending transaction described at transaction level.
  int          cyc = 0;
  bit          armed = 0, rst_seen = 0, busy = 0, lg = 1;
  int          acc_cyc = 0;
  bit          m_id, m_err;
  logic [31:0] m_addr, m_data;
  int          rdc = 0, erc = 0, nrd_low = 0;
  bit          log_on = 0;
  bit          id_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit er0, er1, g, in_read, resp_on, bad_addr;
    if (o_rom_nrd === 1'b0) nrd_low++;
    if (armed) begin
      er0 = 0; er1 = 0; g = 0;
      if (nrst && !busy && (v0 || v1)) begin
        g   = (v0 && v1) ? !lg : v1;
        er0 = (g == 0);
        er1 = (g == 1);
      end
      check_eq("req0_ready", 32'(o_req0_ready), 32'(er0));
      check_eq("req1_ready", 32'(o_req1_ready), 32'(er1));
      in_read = busy && !m_err && (cyc == acc_cyc);
      resp_on = busy && (m_err ? (cyc >= acc_cyc) : (cyc >= acc_cyc + 1));
      check_eq("rom_nrd", 32'(o_rom_nrd), 32'(!in_read));
      check_eq("rom_addr", o_rom_addr, in_read ? m_addr : 32'd0);
      check_eq("resp_valid", 32'(o_resp_valid), 32'(resp_on));
      if (resp_on) begin
        check_eq("resp_data", o_resp_data, m_data);
        check_eq("resp_id", 32'(o_resp_id), 32'(m_id));
        check_eq("resp_err", 32'(o_resp_err), 32'(m_err));
      end
      if (rst_seen) begin
        check_eq("rst_resp_data", o_resp_data, 32'd0);
        check_eq("rst_resp_id", 32'(o_resp_id), 32'd0);
        check_eq("rst_resp_err", 32'(o_resp_err), 32'd0);
      end
      check_eq("rd_count", 32'(o_rd_count), 32'(rdc));
      check_eq("err_count", 32'(o_err_count), 32'(erc));
      if (nrst && ((er0 && v0) || (er1 && v1))) begin
        busy     = 1;
        acc_cyc  = cyc + 1;
        m_id     = g;
        m_addr   = g ? a1 : a0;
        bad_addr = (m_addr % 4 != 0) || ({32'd0, m_addr} + 64'd4 > 64'd100);
        m_err    = bad_addr;
        m_data   = bad_addr ? 32'd0 : word_at(m_addr);
        lg       = g;
        if (log_on) id_log.push_back(g);
      end else if (nrst && resp_on && rr) begin
        busy = 0;
        if (m_err) erc = (erc == 65535) ? erc : erc + 1;
        else       rdc = (rdc == 65535) ? rdc : rdc + 1;
      end
    end
    if (!nrst) begin
      armed = 1; rst_seen = 1; busy = 0; lg = 1; rdc = 0; erc = 0;
    end else begin
      rst_seen = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request on a port and wait (bounded) for acceptance and the response handshake.
  task automatic send(input int p, input logic [31:0] a);
    logic ok;
    int   n;
    rr = 1;
    if (p == 0) begin v0 = 1; a0 = a; end else begin v1 = 1; a1 = a; end
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = (p == 0) ? o_req0_ready : o_req1_ready;
      step(1); n++;
    end
    if (p == 0) v0 = 0; else v1 = 0;
    check_eq("accept_timeout", 32'(ok), 32'd1);
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = o_resp_valid && rr;
      step(1); n++;
    end
    check_eq("resp_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return 32'd96;
      1:       return 32'd97;
      2:       return 32'hFFFF_FFFC;
      3:       return 32'd100;
      4:       return $urandom;
      default: return 32'($urandom_range(0, 24)) * 32'd4;
    endcase
  endfunction

  initial begin
    int          snap_nrd, snap_rd, snap_er, seen, n;
    logic        ok;
    logic [31:0] held_data;
    logic        held_id;
    for (int i = 0; i < 100; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) rom[i] = 8'(i * 17);
    nrst = 0; v0 = 0; v1 = 0; rr = 1; a0 = 0; a1 = 0;
    step(3);
    nrst = 1;
    step(1);

    // 1: single fetch at address 4
    snap_nrd = nrd_low;
    send(0, 32'd4);
    check_eq("t1_nrd_cycles", 32'(nrd_low - snap_nrd), 32'd1);
    check_eq("t1_rd_count", 32'(o_rd_count), 32'd1);

    // 2: both ports held valid from reset, grants must alternate starting with port 0
    nrst = 0; step(1); nrst = 1;
    id_log.delete();
    log_on = 1;
    v0 = 1; a0 = 32'd0; v1 = 1; a1 = 32'd4; rr = 1;
    step(13);
    v0 = 0; v1 = 0; log_on = 0;
    step(4);
    check_eq("t2_grants", 32'(id_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < id_log.size(); i++) check_eq("t2_grant_seq", 32'(id_log[i]), 32'(i % 2));

    // 3: misaligned then out-of-range on the debug port
    snap_nrd = nrd_low; snap_er = int'(o_err_count);
    send(1, 32'd2);
    send(1, 32'd100);
    check_eq("t3_nrd_cycles", 32'(nrd_low - snap_nrd), 32'd0);
    check_eq("t3_err_delta", 32'(int'(o_err_count) - snap_er), 32'd2);

    // 4: boundary addresses
    snap_rd = int'(o_rd_count); snap_er = int'(o_err_count);
    send(0, 32'd96);
    send(0, 32'd97);
    send(0, 32'hFFFF_FFFC);
    check_eq("t4_rd_delta", 32'(int'(o_rd_count) - snap_rd), 32'd1);
    check_eq("t4_err_delta", 32'(int'(o_err_count) - snap_er), 32'd2);

    // 5: consumer stalls for 5 cycles while both requesters keep asking
    snap_rd = int'(o_rd_count);
    rr = 0; v0 = 1; a0 = 32'd8; v1 = 1; a1 = 32'd12;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); ok = o_resp_valid; step(1); n++;
    end
    check_eq("t5_resp_timeout", 32'(ok), 32'd1);
    held_data = o_resp_data; held_id = o_resp_id;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t5_hold_valid", 32'(o_resp_valid), 32'd1);
      check_eq("t5_hold_data", o_resp_data, held_data);
      check_eq("t5_hold_id", 32'(o_resp_id), 32'(held_id));
      check_eq("t5_no_ready", 32'({o_req0_ready, o_req1_ready}), 32'd0);
      step(1);
    end
    rr = 1;
    step(1);
    v0 = 0; v1 = 0;
    @(negedge clk);
    check_eq("t5_released", 32'(o_resp_valid), 32'd0);
    check_eq("t5_rd_delta", 32'(int'(o_rd_count) - snap_rd), 32'd1);
    step(2);

    // 6: reset while the ROM read is in flight
    rr = 1; v0 = 1; a0 = 32'd4;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); ok = o_req0_ready; step(1); n++;
    end
    check_eq("t6_accept_timeout", 32'(ok), 32'd1);
    nrst = 0; v0 = 0;
    step(1);
    nrst = 1;
    @(negedge clk);
    check_eq("t6_rom_nrd", 32'(o_rom_nrd), 32'd1);
    check_eq("t6_resp_valid", 32'(o_resp_valid), 32'd0);
    check_eq("t6_counts", 32'({o_rd_count, o_err_count}), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_resp_valid) seen++;
    end
    check_eq("t6_no_resp", 32'(seen), 32'd0);
    step(1);

    // Random traffic: requesters toggle freely, consumer stalls, occasional reset
    for (int i = 0; i < 3000; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) a0 = rand_addr();
      if ($urandom_range(0, 2) == 0) a1 = rand_addr();
      rr   = ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 299) != 0);
      step(1);
    end
    nrst = 1; v0 = 0; v1 = 0; rr = 1;
    step(5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
